v810_bus_ctlr: RTL and testbench

External-bus controller for the V810 memory interface. It sits between `v810_mem`'s external pins (A, MRQn, RW, BCYSTn, DAn) and the system memories. For each bus cycle it:
- decodes the address into a chip select;
- counts per-region wait states;
- returns READYn/SZRQn to the CPU;
- terminates accesses to unmapped addresses with a timeout and error report.

It replaces the ad-hoc combinational decode and wired READYn/SZRQn logic in the system benches.

---
 rtl/v810_bus_ctlr.sv | 149 ++++++++++++++
 tb/tb_v810_bus_ctlr.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/v810_bus_ctlr.sv
// External-bus controller for the V810: decodes each bus cycle into a chip select,
// counts region wait states, and returns READYn/SZRQn. Unmapped accesses time out and report an error.
module v810_bus_ctlr #(
    parameter int ROM_WS  = 2,
    parameter int RAM_WS  = 0,
    parameter int IO_WS   = 1,
    parameter int TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        CE,
    input  logic        RES,
    input  logic [31:0] A,
    input  logic        MRQn,
    input  logic        RW,
    input  logic        BCYSTn,
    input  logic        DAn,
    output logic        READYn,
    output logic        SZRQn,
    output logic        ROM_CEn,
    output logic        RAM_CEn,
    output logic        IO_CEn,
    output logic        RAM_WEn,
    output logic        BUSERR,
    output logic [31:0] ERR_ADDR
);

    typedef enum logic [1:0] {S_IDLE, S_CNT, S_RDY} state_t;
    typedef enum logic [2:0] {R_NONE, R_RAM, R_ROM, R_IO, R_UNM} region_t;

    function automatic region_t decode(input logic [31:0] a);
        if (!a[31])                   return R_RAM;
        else if (a[31:20] == 12'hFFF) return R_ROM;
        else if (a[31:24] == 8'h80)   return R_IO;
        else                          return R_UNM;
    endfunction

    state_t      state_q, state_d;
    region_t     region_q, region_d;
    logic [31:0] addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  load;

    logic        ready_q, ready_d;
    logic        szrq_q, szrq_d;
    logic        rom_ce_q, rom_ce_d;
    logic        ram_ce_q, ram_ce_d;
    logic        io_ce_q, io_ce_d;
    logic        ram_we_q, ram_we_d;
    logic        buserr_q, buserr_d;
    logic [31:0] err_addr_q, err_addr_d;

    // The data strobe is observed by the system but carries no control meaning here.
    logic unused_dan;
    assign unused_dan = DAn;

    always_comb begin
        state_d  = state_q;
        region_d = region_q;
        addr_d   = addr_q;
        rw_d     = rw_q;
        cnt_d    = cnt_q;
        load     = 8'd0;
        case (state_q)
            S_IDLE: begin
                if (!BCYSTn) begin
                    addr_d = A;
                    rw_d   = RW;
                    if (MRQn) begin
                        region_d = R_NONE;
                        state_d  = S_RDY;
                    end else begin
                        region_d = decode(A);
                        case (region_d)
                            R_RAM:   load = 8'(RAM_WS);
                            R_ROM:   load = 8'(ROM_WS);
                            R_IO:    load = 8'(IO_WS);
                            default: load = 8'(TIMEOUT - 1);
                        endcase
                        // The counter holds the cycles still to wait before READYn;
                        // zero means READYn coincides with the first select cycle.
                        cnt_d   = load;
                        state_d = (load == 8'd0) ? S_RDY : S_CNT;
                    end
                end
            end
            S_CNT: begin
                if (cnt_q <= 8'd1) state_d = S_RDY;
                else               cnt_d   = cnt_q - 8'd1;
            end
            S_RDY:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so selects appear the cycle after acceptance.
    always_comb begin
        rom_ce_d   = !(state_d != S_IDLE && region_d == R_ROM);
        ram_ce_d   = !(state_d != S_IDLE && region_d == R_RAM);
        io_ce_d    = !(state_d != S_IDLE && region_d == R_IO);
        ram_we_d   = ram_ce_d | rw_d;
        ready_d    = (state_d != S_RDY);
        szrq_d     = !(state_d == S_RDY && region_d == R_ROM);
        buserr_d   = (state_d == S_RDY && region_d == R_UNM);
        err_addr_d = buserr_d ? addr_d : err_addr_q;
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q    <= S_IDLE;
            region_q   <= R_NONE;
            addr_q     <= 32'd0;
            rw_q       <= 1'b1;
            cnt_q      <= 8'd0;
            ready_q    <= 1'b1;
            szrq_q     <= 1'b1;
            rom_ce_q   <= 1'b1;
            ram_ce_q   <= 1'b1;
            io_ce_q    <= 1'b1;
            ram_we_q   <= 1'b1;
            buserr_q   <= 1'b0;
            err_addr_q <= 32'd0;
        end else if (CE) begin
            state_q    <= state_d;
            region_q   <= region_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            szrq_q     <= szrq_d;
            rom_ce_q   <= rom_ce_d;
            ram_ce_q   <= ram_ce_d;
            io_ce_q    <= io_ce_d;
            ram_we_q   <= ram_we_d;
            buserr_q   <= buserr_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign READYn   = ready_q;
    assign SZRQn    = szrq_q;
    assign ROM_CEn  = rom_ce_q;
    assign RAM_CEn  = ram_ce_q;
    assign IO_CEn   = io_ce_q;
    assign RAM_WEn  = ram_we_q;
    assign BUSERR   = buserr_q;
    assign ERR_ADDR = err_addr_q;

endmodule

// File: tb/tb_v810_bus_ctlr.sv
// Bench for v810_bus_ctlr: scenario tasks drive bus cycles and push expected terminations;
// a monitor pops and compares them whenever READYn falls.
module tb_v810_bus_ctlr;

    localparam int ROM_WS  = 2;
    localparam int RAM_WS  = 0;
    localparam int IO_WS   = 1;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        CE = 1'b1, RES = 1'b1;
    logic [31:0] A = 32'd0;
    logic        MRQn = 1'b1, RW = 1'b1, BCYSTn = 1'b1, DAn = 1'b1;
    logic        READYn, SZRQn, ROM_CEn, RAM_CEn, IO_CEn, RAM_WEn, BUSERR;
    logic [31:0] ERR_ADDR;

    int errors = 0;
    int checks = 0;
    int ce_cyc = 0;

    typedef struct {
        logic [31:0] addr;
        logic        rw;
        logic        mrqn;
        int          start;
        int          lat;
    } txn_t;
    txn_t sb[$];

    v810_bus_ctlr #(.ROM_WS(ROM_WS), .RAM_WS(RAM_WS), .IO_WS(IO_WS), .TIMEOUT(TIMEOUT)) dut (
        .CLK(clk), .CE(CE), .RES(RES), .A(A), .MRQn(MRQn), .RW(RW), .BCYSTn(BCYSTn), .DAn(DAn),
        .READYn(READYn), .SZRQn(SZRQn), .ROM_CEn(ROM_CEn), .RAM_CEn(RAM_CEn), .IO_CEn(IO_CEn),
        .RAM_WEn(RAM_WEn), .BUSERR(BUSERR), .ERR_ADDR(ERR_ADDR)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (CE && !RES) ce_cyc <= ce_cyc + 1;

    // 0 none, 1 RAM, 2 ROM, 3 IO, 4 unmapped
    function automatic int exp_region(input logic [31:0] a, input logic mrqn);
        if (mrqn)                     return 0;
        if (a[31] == 1'b0)            return 1;
        if (a[31:20] == 12'hFFF)      return 2;
        if (a[31:24] == 8'h80)        return 3;
        return 4;
    endfunction

    function automatic int exp_lat(input int r);
        case (r)
            1:       return 1 + RAM_WS;
            2:       return 1 + ROM_WS;
            3:       return 1 + IO_WS;
            4:       return TIMEOUT;
            default: return 1;
        endcase
    endfunction

    // Scoreboard monitor
    logic ready_prev = 1'b1;
    always @(negedge clk) begin
        txn_t r;
        int   reg_e;
        logic [5:0] exp_v, got_v;
        checks++;
        if (int'(ROM_CEn) + int'(RAM_CEn) + int'(IO_CEn) < 2) begin
            errors++;
            $display("FAIL onehot_cs: got rom=%b ram=%b io=%b, required at most one low", ROM_CEn, RAM_CEn, IO_CEn);
        end
        if (READYn === 1'b0 && ready_prev === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready: READYn fell with no cycle outstanding");
            end else begin
                r     = sb.pop_front();
                reg_e = exp_region(r.addr, r.mrqn);
                exp_v = {reg_e != 2, reg_e != 1, reg_e != 3, !(reg_e == 1 && !r.rw), reg_e != 2, reg_e == 4};
                got_v = {ROM_CEn, RAM_CEn, IO_CEn, RAM_WEn, SZRQn, BUSERR};
                $display("txn addr=%08h rw=%b mrqn=%b lat=%0d outs(rom,ram,io,we,sz,be)=%b", r.addr, r.rw, r.mrqn,
                         ce_cyc - r.start, got_v);
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL sb_outputs addr=%08h: got %b, required %b", r.addr, got_v, exp_v);
                end
                checks++;
                if (ce_cyc - r.start != r.lat) begin
                    errors++;
                    $display("FAIL sb_latency addr=%08h: got %0d, required %0d", r.addr, ce_cyc - r.start, r.lat);
                end
                if (reg_e == 4) begin
                    checks++;
                    if (ERR_ADDR !== r.addr) begin
                        errors++;
                        $display("FAIL sb_err_addr: got %08h, required %08h", ERR_ADDR, r.addr);
                    end
                end
            end
        end
        ready_prev = READYn;
    end

    // Called at a negedge in IDLE; returns at the negedge of cycle T+1.
    task automatic start_cycle(input logic [31:0] addr, input logic rw, input logic mrqn);
        txn_t t;
        t.addr  = addr;
        t.rw    = rw;
        t.mrqn  = mrqn;
        t.start = ce_cyc;
        t.lat   = exp_lat(exp_region(addr, mrqn));
        sb.push_back(t);
        A = addr; RW = rw; MRQn = mrqn; BCYSTn = 1'b0;
        @(negedge clk);
        BCYSTn = 1'b1;
    endtask

    task automatic wait_ready(input int max, output int n);
        n = 0;
        while (READYn !== 1'b0 && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        RES = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({READYn, SZRQn, ROM_CEn, RAM_CEn, IO_CEn, RAM_WEn, BUSERR} !== 7'b1111110) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 1111110",
                     {READYn, SZRQn, ROM_CEn, RAM_CEn, IO_CEn, RAM_WEn, BUSERR});
        end
        checks++;
        if (ERR_ADDR !== 32'd0) begin
            errors++;
            $display("FAIL reset_err_addr: got %08h, required 00000000", ERR_ADDR);
        end
        RES = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ram_read();
        int n;
        start_cycle(32'h0000_0100, 1'b1, 1'b0);
        checks++;
        if ({RAM_CEn, READYn, SZRQn, RAM_WEn} !== 4'b0011) begin
            errors++;
            $display("FAIL ram_read_t1: got ce,rdy,sz,we=%b, required 0011", {RAM_CEn, READYn, SZRQn, RAM_WEn});
        end
        wait_ready(4, n);
        @(negedge clk);
        checks++;
        if ({ROM_CEn, RAM_CEn, IO_CEn, RAM_WEn, READYn, SZRQn} !== 6'h3F) begin
            errors++;
            $display("FAIL ram_read_t2: got %b, required 111111", {ROM_CEn, RAM_CEn, IO_CEn, RAM_WEn, READYn, SZRQn});
        end
    endtask

    task automatic test_ram_write();
        int n;
        start_cycle(32'h0000_0200, 1'b0, 1'b0);
        checks++;
        if ({RAM_CEn, RAM_WEn, READYn} !== 3'b000) begin
            errors++;
            $display("FAIL ram_write_t1: got ce,we,rdy=%b, required 000", {RAM_CEn, RAM_WEn, READYn});
        end
        wait_ready(4, n);
        @(negedge clk);
        checks++;
        if ({RAM_CEn, RAM_WEn, READYn} !== 3'b111) begin
            errors++;
            $display("FAIL ram_write_t2: got ce,we,rdy=%b, required 111", {RAM_CEn, RAM_WEn, READYn});
        end
    endtask

    task automatic test_back_to_back();
        int n;
        for (int k = 0; k < 2; k++) begin
            start_cycle(32'hFFF0_0000, 1'b1, 1'b0);
            checks++;
            if ({ROM_CEn, READYn} !== 2'b01) begin
                errors++;
                $display("FAIL rom_b2b_t1[%0d]: got ce,rdy=%b, required 01", k, {ROM_CEn, READYn});
            end
            wait_ready(10, n);
            checks++;
            if (n != ROM_WS || SZRQn !== 1'b0) begin
                errors++;
                $display("FAIL rom_b2b_ready[%0d]: got wait=%0d sz=%b, required wait=%0d sz=0", k, n, SZRQn, ROM_WS);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_unmapped();
        int n;
        start_cycle(32'hC000_0000, 1'b1, 1'b0);
        wait_ready(TIMEOUT + 4, n);
        checks++;
        if (n != TIMEOUT - 1 || BUSERR !== 1'b1) begin
            errors++;
            $display("FAIL unmapped_timeout: got wait=%0d buserr=%b, required wait=%0d buserr=1", n, BUSERR, TIMEOUT - 1);
        end
        @(negedge clk);
        checks++;
        if (BUSERR !== 1'b0 || ERR_ADDR !== 32'hC000_0000) begin
            errors++;
            $display("FAIL unmapped_after: got buserr=%b err_addr=%08h, required 0 / c0000000", BUSERR, ERR_ADDR);
        end
    endtask

    task automatic test_decode();
        logic [31:0] addrs [7] = '{32'h7FFF_FFFC, 32'h4000_0000, 32'hFFFF_FFF0, 32'h80FF_0000,
                                   32'hFFEF_FFFF, 32'h8100_0000, 32'h1234_5678};
        logic        mrqs  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        rws   [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        int n;
        for (int k = 0; k < 7; k++) begin
            start_cycle(addrs[k], rws[k], mrqs[k]);
            wait_ready(TIMEOUT + 4, n);
            checks++;
            if (READYn !== 1'b0) begin
                errors++;
                $display("FAIL decode_timeout[%0d]: READYn got %b, required 0", k, READYn);
            end
            @(negedge clk);
            checks++;
            if ({ROM_CEn, RAM_CEn, IO_CEn, RAM_WEn, READYn, SZRQn} !== 6'h3F) begin
                errors++;
                $display("FAIL decode_idle[%0d]: got %b, required 111111", k,
                         {ROM_CEn, RAM_CEn, IO_CEn, RAM_WEn, READYn, SZRQn});
            end
        end
    endtask

    task automatic test_ce_gating();
        logic extra;
        start_cycle(32'h8000_0010, 1'b1, 1'b0);
        CE = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({IO_CEn, READYn} !== 2'b01) begin
            errors++;
            $display("FAIL ce_hold: got ce,rdy=%b, required 01", {IO_CEn, READYn});
        end
        CE = 1'b1;
        A = 32'hFFF0_0000; MRQn = 1'b0; BCYSTn = 1'b0;
        @(negedge clk);
        BCYSTn = 1'b1;
        checks++;
        if ({IO_CEn, READYn, SZRQn} !== 3'b001) begin
            errors++;
            $display("FAIL ce_ready: got ce,rdy,sz=%b, required 001", {IO_CEn, READYn, SZRQn});
        end
        extra = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (READYn !== 1'b1 || ROM_CEn !== 1'b1) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL spurious_bcyst: got extra activity, required idle");
        end
    endtask

    task automatic test_reset_mid();
        int n;
        start_cycle(32'hFFF0_0004, 1'b1, 1'b0);
        RES = 1'b1; CE = 1'b0;
        @(negedge clk);
        sb.delete();
        checks++;
        if ({READYn, SZRQn, ROM_CEn, RAM_CEn, IO_CEn, RAM_WEn, BUSERR} !== 7'b1111110 || ERR_ADDR !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: got %b err=%08h, required 1111110 err=00000000",
                     {READYn, SZRQn, ROM_CEn, RAM_CEn, IO_CEn, RAM_WEn, BUSERR}, ERR_ADDR);
        end
        RES = 1'b0; CE = 1'b1;
        @(negedge clk);
        start_cycle(32'h0000_0300, 1'b0, 1'b0);
        checks++;
        if ({RAM_CEn, RAM_WEn, READYn} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_ram: got ce,we,rdy=%b, required 000", {RAM_CEn, RAM_WEn, READYn});
        end
        wait_ready(4, n);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_ram_read();
        test_ram_write();
        test_back_to_back();
        test_unmapped();
        test_decode();
        test_ce_gating();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d outstanding, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
